// File: rtl/acp_bus_arbiter.sv
// acp_bus_arbiter -- N-master shared-bus arbiter with rotating priority,
// tenure limit with preemption, and a combinational output mux driven from
// the registered grant.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       bus request, one bit per master
//   ack       one-hot grant (registered), zero when bus idle
//   bus_in    master data outputs, master i at [i*BUS_WIDTH +: BUS_WIDTH]
//   ctrl_in   master ctrl outputs, master i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   bus_out   shared data bus (zero when idle)
//   ctrl_out  shared ctrl bus (zero when idle)
//   grant_id  index of current owner, meaningful while busy
//   busy      bus owned (= |ack)

// Per-master output gate: passes the master's bus/ctrl only while granted.
// The granted lanes are OR-ed together in the top; since ack is one-hot,
// exactly one lane (or none) contributes, and ungranted X's are masked.
module acp_bus_arbiter_lane #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  sel_i,
  input  logic [BUS_WIDTH-1:0]  bus_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic [BUS_WIDTH-1:0]  bus_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o
);
  assign bus_o  = sel_i ? bus_i  : '0;
  assign ctrl_o = sel_i ? ctrl_i : '0;
endmodule

module acp_bus_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int MAX_HOLD    = 16,
  parameter int ID_WIDTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            req,
  output logic [NUM_MASTERS-1:0]            ack,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  bus_in,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]              bus_out,
  output logic [CTRL_WIDTH-1:0]             ctrl_out,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              busy
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  // Only meaningful when MAX_HOLD != 0; the compare below is gated on that.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [ID_WIDTH-1:0]    gid_q, gid_d;
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   win_vld;
  logic [ID_WIDTH-1:0]    win_idx;
  logic                   own_req;
  logic                   others_wait;

  // Rotating-priority pick: first requester scanning upward from last+1,
  // wrapping modulo NUM_MASTERS. The last owner is therefore lowest priority.
  function automatic logic [ID_WIDTH:0] pick(input logic [NUM_MASTERS-1:0] cand,
                                             input logic [ID_WIDTH-1:0]    last);
    logic [ID_WIDTH:0] res;
    int                idx;
    res = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = (int'(last) + off) % NUM_MASTERS;
      if (!res[ID_WIDTH] && cand[idx]) res = {1'b1, ID_WIDTH'(idx)};
    end
    return res;
  endfunction

  // While in GRANT the owner's request is either high (no arbitration used)
  // or low (so it cannot win), so the raw req vector serves every state.
  assign {win_vld, win_idx} = pick(req, last_q);
  assign own_req     = |(req & ack_q);
  assign others_wait = |(req & ~ack_q);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      GRANT: begin
        if (!own_req) begin
          // Owner released: hand over on the same edge, no dead cycle.
          if (win_vld) begin
            ack_d  = NUM_MASTERS'(1) << win_idx;
            gid_d  = win_idx;
            last_d = win_idx;
            cnt_d  = '0;
          end else begin
            ack_d   = '0;
            state_d = IDLE;
          end
        end else if (MAX_HOLD != 0 && cnt_q == HOLD_LAST && others_wait) begin
          ack_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin  // IDLE and RELEASE arbitrate identically
        if (win_vld) begin
          ack_d   = NUM_MASTERS'(1) << win_idx;
          gid_d   = win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          ack_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= '0;
      gid_q   <= '0;
      last_q  <= ID_WIDTH'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = gid_q;
  assign busy     = |ack_q;

  // Output mux: gate each lane by its ack bit, then OR the lanes.
  logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0]  lane_bus;
  logic [NUM_MASTERS-1:0][CTRL_WIDTH-1:0] lane_ctrl;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    acp_bus_arbiter_lane #(
      .BUS_WIDTH (BUS_WIDTH),
      .CTRL_WIDTH(CTRL_WIDTH)
    ) u_lane (
      .sel_i (ack_q[i]),
      .bus_i (bus_in[i*BUS_WIDTH +: BUS_WIDTH]),
      .ctrl_i(ctrl_in[i*CTRL_WIDTH +: CTRL_WIDTH]),
      .bus_o (lane_bus[i]),
      .ctrl_o(lane_ctrl[i])
    );
  end

  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus_out  = bus_out  | lane_bus[i];
      ctrl_out = ctrl_out | lane_ctrl[i];
    end
  end

endmodule

// File: tb/tb_acp_bus_arbiter.sv
module tb_acp_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u_a: 8 masters, MAX_HOLD=4
  logic [7:0]   req_a, ack_a;
  logic [255:0] bus_in_a;
  logic [63:0]  ctrl_in_a;
  logic [31:0]  bus_out_a;
  logic [7:0]   ctrl_out_a;
  logic [3:0]   gid_a;
  logic         busy_a;

  // u_b: 8 masters, MAX_HOLD=0 (unlimited)
  logic [7:0]   req_b, ack_b;
  logic [255:0] bus_in_b;
  logic [63:0]  ctrl_in_b;
  logic [31:0]  bus_out_b;
  logic [7:0]   ctrl_out_b;
  logic [3:0]   gid_b;
  logic         busy_b;

  // u_c: 3 masters, 16-bit bus
  logic [2:0]   req_c, ack_c;
  logic [47:0]  bus_in_c;
  logic [23:0]  ctrl_in_c;
  logic [15:0]  bus_out_c;
  logic [7:0]   ctrl_out_c;
  logic [3:0]   gid_c;
  logic         busy_c;

  int errors = 0;
  int checks = 0;

  acp_bus_arbiter #(.NUM_MASTERS(8), .BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_HOLD(4), .ID_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a), .bus_in(bus_in_a), .ctrl_in(ctrl_in_a),
    .bus_out(bus_out_a), .ctrl_out(ctrl_out_a), .grant_id(gid_a), .busy(busy_a));

  acp_bus_arbiter #(.NUM_MASTERS(8), .BUS_WIDTH(32), .CTRL_WIDTH(8), .MAX_HOLD(0), .ID_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b), .bus_in(bus_in_b), .ctrl_in(ctrl_in_b),
    .bus_out(bus_out_b), .ctrl_out(ctrl_out_b), .grant_id(gid_b), .busy(busy_b));

  acp_bus_arbiter #(.NUM_MASTERS(3), .BUS_WIDTH(16), .CTRL_WIDTH(8), .MAX_HOLD(16), .ID_WIDTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .ack(ack_c), .bus_in(bus_in_c), .ctrl_in(ctrl_in_c),
    .bus_out(bus_out_c), .ctrl_out(ctrl_out_c), .grant_id(gid_c), .busy(busy_c));

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (ack_a !== 8'h00)      begin errors++; $display("FAIL reset_ack: got %h expected 00", ack_a); end
    checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (gid_a !== 4'd0)       begin errors++; $display("FAIL reset_gid: got %0d expected 0", gid_a); end
    checks++; if (bus_out_a !== 32'h0)  begin errors++; $display("FAIL reset_bus: got %h expected 0", bus_out_a); end
    checks++; if (ctrl_out_a !== 8'h0)  begin errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_out_a); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_grant();
    req_a = 8'h80;
    #1;
    checks++; if (ack_a !== 8'h00) begin errors++; $display("FAIL grant_latency: got %h expected 00", ack_a); end
    tick();
    checks++; if (ack_a !== 8'h80)          begin errors++; $display("FAIL grant7_ack: got %h expected 80", ack_a); end
    checks++; if (gid_a !== 4'd7)           begin errors++; $display("FAIL grant7_gid: got %0d expected 7", gid_a); end
    checks++; if (bus_out_a !== 32'hDEADBEEF) begin errors++; $display("FAIL grant7_bus: got %h expected deadbeef", bus_out_a); end
    checks++; if (ctrl_out_a !== 8'hA7)     begin errors++; $display("FAIL grant7_ctrl: got %h expected a7", ctrl_out_a); end
    checks++; if (busy_a !== 1'b1)          begin errors++; $display("FAIL grant7_busy: got %b expected 1", busy_a); end
    req_a = 8'h00;
    tick();
    checks++; if (ack_a !== 8'h00)      begin errors++; $display("FAIL idle_ack: got %h expected 00", ack_a); end
    checks++; if (bus_out_a !== 32'h0)  begin errors++; $display("FAIL idle_bus: got %h expected 0", bus_out_a); end
    checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_a); end
  endtask

  // All masters request; each owner drops for one cycle after 3 granted
  // cycles. Pointer sits at 7 from the previous test, so master 0 starts.
  task automatic test_back_to_back();
    logic [7:0] exp;
    req_a = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      exp = 8'(1) << (n % 8);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (ack_a !== exp || busy_a !== 1'b1 || gid_a !== 4'(n % 8)) begin
          errors++;
          $display("FAIL rr_owner n=%0d c=%0d: got ack=%h gid=%0d busy=%b expected ack=%h gid=%0d busy=1",
                   n, c, ack_a, gid_a, busy_a, exp, n % 8);
        end
        if (c < 2) tick();
      end
      req_a = 8'hFF & ~exp;
      tick();
      req_a = 8'hFF;
    end
    req_a = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_preempt();
    logic [7:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_a = 8'h03;
    tick();
    // Period 5: 4 owned cycles + 1 turnaround, alternating masters 0 and 1.
    for (int c = 0; c < 15; c++) begin
      exp = ((c % 5) < 4) ? (8'(1) << ((c / 5) % 2)) : 8'h00;
      checks++;
      if (ack_a !== exp) begin
        errors++; $display("FAIL preempt_ack c=%0d: got %h expected %h", c, ack_a, exp);
      end
      if (exp == 8'h00) begin
        checks++;
        if (busy_a !== 1'b0 || bus_out_a !== 32'h0) begin
          errors++; $display("FAIL preempt_release c=%0d: got busy=%b bus=%h expected busy=0 bus=0", c, busy_a, bus_out_a);
        end
      end
      tick();
    end
    req_a = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_unlimited_hold();
    req_b = 8'h03;
    tick();
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (ack_b !== 8'h01) begin errors++; $display("FAIL nolimit_ack c=%0d: got %h expected 01", c, ack_b); end
      tick();
    end
    req_b = 8'h00;
    // Single requester with a tenure limit: nobody waits, so no preemption.
    req_a = 8'h01;
    tick();
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (ack_a !== 8'h01) begin errors++; $display("FAIL single_hold c=%0d: got %h expected 01", c, ack_a); end
      tick();
    end
    req_a = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    req_a = 8'h20;
    tick();
    checks++; if (ack_a !== 8'h20) begin errors++; $display("FAIL ar_grant5: got %h expected 20", ack_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ack_a !== 8'h00) begin errors++; $display("FAIL ar_ack: got %h expected 00", ack_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", busy_a); end
    tick();
    req_a = 8'h24;
    rst_n = 1'b1;
    tick();
    checks++; if (ack_a !== 8'h04) begin errors++; $display("FAIL ar_first: got %h expected 04", ack_a); end
    checks++; if (gid_a !== 4'd2)  begin errors++; $display("FAIL ar_gid: got %0d expected 2", gid_a); end
    req_a = 8'h00;
    tick();
  endtask

  task automatic test_small_config();
    req_c = 3'b101;
    tick();
    checks++; if (ack_c !== 3'b001) begin errors++; $display("FAIL n3_first: got %b expected 001", ack_c); end
    req_c = 3'b100;
    tick();
    checks++; if (ack_c !== 3'b100)     begin errors++; $display("FAIL n3_handover: got %b expected 100", ack_c); end
    checks++; if (gid_c !== 4'd2)       begin errors++; $display("FAIL n3_gid: got %0d expected 2", gid_c); end
    checks++; if (ctrl_out_c !== 8'hC2) begin errors++; $display("FAIL n3_ctrl: got %h expected c2", ctrl_out_c); end
    checks++; if (bus_out_c !== 16'hB002) begin errors++; $display("FAIL n3_bus: got %h expected b002", bus_out_c); end
    req_c = 3'b000;
    tick();
    checks++; if (ack_c !== 3'b000 || bus_out_c !== 16'h0) begin
      errors++; $display("FAIL n3_idle: got ack=%b bus=%h expected ack=000 bus=0", ack_c, bus_out_c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    for (int i = 0; i < 8; i++) begin
      bus_in_a[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ctrl_in_a[i*8 +: 8]  = 8'hA0 + 8'(i);
      bus_in_b[i*32 +: 32] = 32'h2000_0000 + 32'(i);
      ctrl_in_b[i*8 +: 8]  = 8'hB0 + 8'(i);
    end
    bus_in_a[7*32 +: 32] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      bus_in_c[i*16 +: 16] = 16'hB000 + 16'(i);
      ctrl_in_c[i*8 +: 8]  = 8'hC0 + 8'(i);
    end
    #1;
    test_reset();
    test_basic_grant();
    test_back_to_back();
    test_preempt();
    test_unlimited_hold();
    test_async_reset();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
